// File: rtl/fullsend_pkg.sv
// Shared widths, arbitration limits and FSM state encoding for the
// data-memory arbiter between the core MEM stage and the debug/loader host.
package fullsend_pkg;

    localparam int ADDR_W       = 11;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;
    localparam int BURST_MAX    = 4;

    typedef enum logic [0:0] {
        S_CORE = 1'b0,
        S_HOST = 1'b1
    } arb_state_t;

    // Bits needed to hold every count from 0 up to and including max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: core has priority, the host is guaranteed
// a slot after STARVE_LIMIT-1 contended core grants and then a bounded burst.
module dmem_arbiter #(
    parameter int ADDR_W       = fullsend_pkg::ADDR_W,
    parameter int DATA_W       = fullsend_pkg::DATA_W,
    parameter int STARVE_LIMIT = fullsend_pkg::STARVE_LIMIT,
    parameter int BURST_MAX    = fullsend_pkg::BURST_MAX
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import fullsend_pkg::arb_state_t;
    import fullsend_pkg::S_CORE;
    import fullsend_pkg::S_HOST;
    import fullsend_pkg::cnt_width;

    localparam int STARVE_W = cnt_width(STARVE_LIMIT);
    localparam int BURST_W  = cnt_width(BURST_MAX);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
    // The grant that enters S_HOST is already the first of the burst, so the
    // burst ends on the S_HOST grant seen with burst_cnt == BURST_MAX-2.
    localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(BURST_MAX - 2);

    arb_state_t state_q;
    arb_state_t state_d;

    logic core_grant;
    logic host_grant;
    logic starve_inc;
    logic starve_clr;
    logic burst_inc;
    logic burst_clr;
    logic rd_pend_q;
    logic rd_pend_d;
    logic owner_q;
    logic owner_d;
    logic load_grant;

    logic [STARVE_W-1:0] starve_cnt;
    logic [BURST_W-1:0]  burst_cnt;

    // Grants are suppressed while reset is held so the memory sees no command.
    always_comb begin
        state_d    = state_q;
        core_grant = 1'b0;
        host_grant = 1'b0;
        starve_inc = 1'b0;
        if (reset) begin
            case (state_q)
                S_CORE: begin
                    if (core_req && host_req) begin
                        if (starve_cnt == STARVE_LAST) begin
                            host_grant = 1'b1;
                            state_d    = S_HOST;
                        end else begin
                            core_grant = 1'b1;
                            starve_inc = 1'b1;
                        end
                    end else if (core_req) begin
                        core_grant = 1'b1;
                    end else if (host_req) begin
                        host_grant = 1'b1;
                    end
                end
                S_HOST: begin
                    if (host_req) begin
                        host_grant = 1'b1;
                        if (burst_cnt == BURST_LAST) begin
                            state_d = S_CORE;
                        end
                    end else begin
                        core_grant = core_req;
                        state_d    = S_CORE;
                    end
                end
                default: begin
                    state_d = S_CORE;
                end
            endcase
        end
    end

    assign starve_clr = host_grant || !host_req;
    assign burst_inc  = host_grant && (state_q == S_HOST);
    assign burst_clr  = (state_q == S_CORE);

    arb_sat_counter #(
        .WIDTH (STARVE_W)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .count (starve_cnt)
    );

    arb_sat_counter #(
        .WIDTH (BURST_W)
    ) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (burst_inc),
        .clr   (burst_clr),
        .count (burst_cnt)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_grant) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (host_grant) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign core_stall = core_req && !core_grant;
    assign host_gnt   = host_grant;

    // The owner flag remembers who issued the load so the returning word is
    // steered to that port only; stores leave no return pending.
    assign load_grant = mem_en && !mem_we;

    always_comb begin
        rd_pend_d = load_grant;
        owner_d   = owner_q;
        if (load_grant) begin
            owner_d = host_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_CORE;
            rd_pend_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            owner_q   <= owner_d;
        end
    end

    assign core_rvalid = rd_pend_q && !owner_q;
    assign host_rvalid = rd_pend_q && owner_q;
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration/memory model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    import fullsend_pkg::S_CORE;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int SL = 8;
    localparam int BM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // Synchronous single-port memory driven only by the DUT command.
    logic [DW-1:0] env_mem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) env_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) env_mem[mem_addr] = mem_wdata;
                else        mem_rdata = env_mem[mem_addr];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] m_mem [0:2047];
    bit            m_host_mode;
    int            m_starve;
    int            m_burst;
    bit            m_rd_pend;
    bit            m_rd_host;
    logic [DW-1:0] m_rd_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit            ecg, ehg, e_en, e_we, load;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        ecg = 0; ehg = 0;
        if (reset) begin
            if (!m_host_mode) begin
                if (core_req && host_req) begin
                    if (m_starve == SL - 1) ehg = 1;
                    else                    ecg = 1;
                end else if (core_req) ecg = 1;
                else if (host_req)     ehg = 1;
            end else begin
                if (host_req) ehg = 1;
                else          ecg = core_req;
            end
        end
        e_en = ecg || ehg;
        e_we = ecg ? core_we : (ehg ? host_we : 1'b0);
        e_addr = ecg ? core_addr : (ehg ? host_addr : '0);
        e_wd   = ecg ? core_wdata : (ehg ? host_wdata : '0);

        chk("host_gnt",    32'(host_gnt),    32'(ehg));
        chk("core_stall",  32'(core_stall),  32'(core_req && !ecg));
        chk("mem_en",      32'(mem_en),      32'(e_en));
        chk("mem_we",      32'(mem_we),      32'(e_we));
        chk("mem_addr",    32'(mem_addr),    32'(e_addr));
        chk("mem_wdata",   mem_wdata,        e_wd);
        chk("core_rvalid", 32'(core_rvalid), 32'(reset && m_rd_pend && !m_rd_host));
        chk("host_rvalid", 32'(host_rvalid), 32'(reset && m_rd_pend && m_rd_host));
        chk("core_rdata",  core_rdata, (reset && m_rd_pend && !m_rd_host) ? m_rd_data : '0);
        chk("host_rdata",  host_rdata, (reset && m_rd_pend && m_rd_host) ? m_rd_data : '0);

        if (!reset) begin
            m_host_mode = 0; m_starve = 0; m_burst = 0; m_rd_pend = 0; m_rd_host = 0;
        end else begin
            load = e_en && !e_we;
            m_rd_pend = load;
            if (load) begin
                m_rd_host = ehg;
                m_rd_data = m_mem[e_addr];
            end
            if (e_en && e_we) m_mem[e_addr] = e_wd;
            if (!m_host_mode) begin
                if (ecg && host_req && m_starve < SL - 1) m_starve++;
                if (ehg && core_req) begin
                    m_host_mode = 1;
                    m_burst = 1;
                end
            end else if (ehg) begin
                m_burst++;
                if (m_burst == BM) m_host_mode = 0;
            end else begin
                m_host_mode = 0;
            end
            if (ehg || !host_req) m_starve = 0;
        end
    endtask

    task automatic step(input logic rst,
                        input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd);
        @(posedge clk);
        #1;
        reset = rst;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle();
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    logic [11:0]   hg, cg;
    int            mode;
    logic          r_cr, r_cw, r_hr, r_hw;
    logic [AW-1:0] r_ca, r_ha;

    initial begin
        for (int i = 0; i < 2048; i++) m_mem[i] = init_val(i);
        m_host_mode = 0; m_starve = 0; m_burst = 0; m_rd_pend = 0; m_rd_host = 0; m_rd_data = '0;
        reset = 0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        #1;
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_mem_en",      32'(mem_en),      32'd0);

        // Requests during reset: no grant, core stalls.
        step(0, 1, 0, 11'h003, '0, 1, 0, 11'h004, '0);
        chk("rst_stall", 32'(core_stall), 32'd1);
        chk("rst_hgnt",  32'(host_gnt),   32'd0);
        idle();

        // Host store at the top address with the core idle.
        step(1, 0, 0, '0, '0, 1, 1, 11'h7FF, 32'h1234_5678);
        chk("hst_gnt",   32'(host_gnt), 32'd1);
        chk("hst_we",    32'(mem_we),   32'd1);
        chk("hst_addr",  32'(mem_addr), 32'h7FF);
        chk("hst_wdata", mem_wdata,     32'h1234_5678);
        idle();
        chk("hst_no_crv", 32'(core_rvalid), 32'd0);
        chk("hst_no_hrv", 32'(host_rvalid), 32'd0);

        // Core load returning a preloaded word.
        step(1, 0, 0, '0, '0, 1, 1, 11'h010, 32'hDEAD_BEEF);
        step(1, 1, 0, 11'h010, '0, 0, 0, '0, '0);
        chk("cld_mem_en", 32'(mem_en),     32'd1);
        chk("cld_stall",  32'(core_stall), 32'd0);
        idle();
        chk("cld_rvalid", 32'(core_rvalid), 32'd1);
        chk("cld_rdata",  core_rdata,       32'hDEAD_BEEF);
        chk("cld_stall1", 32'(core_stall),  32'd0);

        // Sustained contention for 12 cycles.
        idle();
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, AW'(i), '0, 1, 0, AW'(i + 32), '0);
            hg[i] = host_gnt;
            cg[i] = mem_en && !host_gnt;
        end
        chk("cont_host_seq", 32'(hg), 32'h780);
        chk("cont_core_seq", 32'(cg), 32'h87F);

        // Host drops its request while owning the port.
        idle();
        for (int i = 0; i < 8; i++) step(1, 1, 1, AW'(i), 32'(i), 1, 1, AW'(i + 8), 32'(i + 100));
        chk("yield_in_host", 32'(host_gnt), 32'd1);
        step(1, 1, 0, 11'h020, '0, 0, 0, '0, '0);
        chk("yield_core_en", 32'(mem_en),     32'd1);
        chk("yield_hgnt",    32'(host_gnt),   32'd0);
        chk("yield_stall",   32'(core_stall), 32'd0);
        idle();
        chk("yield_state", 32'(dut.state_q), 32'(S_CORE));

        // Alternating core and host loads on consecutive grants.
        step(1, 0, 0, '0, '0, 1, 1, 11'h001, 32'hA5A5_0001);
        step(1, 0, 0, '0, '0, 1, 1, 11'h002, 32'h5A5A_0002);
        step(1, 1, 0, 11'h001, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 1, 0, 11'h002, '0);
        chk("alt_crv", 32'(core_rvalid), 32'd1);
        chk("alt_crd", core_rdata,       32'hA5A5_0001);
        chk("alt_hrv", 32'(host_rvalid), 32'd0);
        idle();
        chk("alt_hrv2", 32'(host_rvalid), 32'd1);
        chk("alt_hrd2", host_rdata,       32'h5A5A_0002);
        chk("alt_crv2", 32'(core_rvalid), 32'd0);

        // Reset asserted between a core load grant and its return.
        idle();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 11'h010, '0, 1, 0, 11'h011, '0);
        chk("mid_grant", 32'(mem_en && !host_gnt), 32'd1);
        #1;
        reset = 0;
        #1;
        chk("mid_crv",    32'(core_rvalid),     32'd0);
        chk("mid_en",     32'(mem_en),          32'd0);
        chk("mid_state",  32'(dut.state_q),     32'(S_CORE));
        chk("mid_starve", 32'(dut.starve_cnt),  32'd0);
        chk("mid_burst",  32'(dut.burst_cnt),   32'd0);
        step(0, 0, 0, '0, '0, 0, 0, '0, '0);
        idle();
        chk("mid_after_crv", 32'(core_rvalid), 32'd0);
        chk("mid_after_hrv", 32'(host_rvalid), 32'd0);

        // Randomised traffic with occasional resets.
        mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ((cyc % 64) == 0) mode = $urandom_range(0, 2);
            case (mode)
                0:       begin r_cr = ($urandom_range(0, 99) < 55); r_hr = ($urandom_range(0, 99) < 45); end
                1:       begin r_cr = 1'b1; r_hr = ($urandom_range(0, 9) != 0); end
                default: begin r_cr = ($urandom_range(0, 99) < 30); r_hr = ($urandom_range(0, 99) < 80); end
            endcase
            r_cw = ($urandom_range(0, 2) == 0);
            r_hw = ($urandom_range(0, 2) == 0);
            r_ca = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            r_ha = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            step(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                 r_cr, r_cw, r_ca, 32'($urandom), r_hr, r_hw, r_ha, 32'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: ADDR_W=11 (2048-word data memory); DATA_W=32; STARVE_LIMIT=8 (max host wait cycles under contention); BURST_MAX=4 (max consecutive host grants while core waits).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 core_req  in  1  pipeline MEM-stage access request.
REQ-006 core_we  in  1  core store (1) / load (0).
REQ-007 core_addr  in  ADDR_W  core word address.
REQ-008 core_wdata  in  DATA_W  core store data.
REQ-009 core_stall  out  1  core_req pending and not granted this cycle.
REQ-010 core_rvalid  out  1  core load data valid; one cycle after load grant.
REQ-011 core_rdata  out  DATA_W  core load data.
REQ-012 host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  debug/loader port request, same meaning as core fields.
REQ-013 host_gnt  out  1  host request accepted this cycle.
REQ-014 host_rvalid, host_rdata  out  1/DATA_W  host load return; one cycle after load grant.
REQ-015 mem_en, mem_we, mem_addr, mem_wdata  out  1/1/ADDR_W/DATA_W  single-port synchronous memory command.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en && !mem_we.

Function
REQ-017 At most one requester is granted per cycle; the grant drives mem_* combinationally from that requester's fields in the same cycle.
REQ-018 mem_en = core grant || host_gnt; mem_* fields are 0 when mem_en=0.
REQ-019 core_stall = core_req && !core grant (combinational).
REQ-020 FSM states: S_CORE (core priority), S_HOST (host owns port); reset state S_CORE.
REQ-021 S_CORE: core_req -> grant core; else host_req -> grant host; neither -> idle.
REQ-022 S_CORE, both requesting: starve_cnt increments each cycle core is granted; when starve_cnt == STARVE_LIMIT-1 the host is granted that cycle instead, and next state is S_HOST.
REQ-023 starve_cnt clears on any host grant and whenever host_req=0; saturates, never wraps.
REQ-024 S_HOST: host_req -> grant host, burst_cnt increments; after the BURST_MAX-th consecutive host grant, next state S_CORE.
REQ-025 S_HOST, host_req=0: grant core if core_req (no dead cycle); next state S_CORE.
REQ-026 burst_cnt clears on entry to S_HOST and in S_CORE.
REQ-027 Read return: a 1-bit owner flag registered at load grant selects routing of mem_rdata to core_rdata/core_rvalid or host_rdata/host_rvalid on the next cycle; stores produce no rvalid.
REQ-028 Back-to-back loads from alternating owners return in grant order, one per cycle.
REQ-029 rdata outputs not selected as valid are held at 0.

Reset
REQ-030 On reset assertion: state=S_CORE, starve_cnt=0, burst_cnt=0, owner flag=0, core_rvalid=0, host_rvalid=0 immediately, independent of clk.
REQ-031 Reset mid-access discards any in-flight load return; no rvalid after deassertion until a new load grant.
REQ-032 During reset: mem_en=0, host_gnt=0; core_stall follows REQ-019 with no grant.

Structure
REQ-033 Shared package fullsend_pkg holds ADDR_W, DATA_W and the enum arb_state_t {S_CORE, S_HOST}.
REQ-034 One sub-module arb_sat_counter (parameterised width, inc/clr, saturating) used for starve_cnt and burst_cnt; grant logic and FSM stay in dmem_arbiter.

Verification
REQ-035 Core-only load addr 0x010, mem holds 0xDEADBEEF -> mem_en cycle N, core_rvalid=1 and core_rdata=0xDEADBEEF cycle N+1, core_stall=0 throughout.
REQ-036 core_req and host_req both held 12 cycles -> core granted cycles 0-6, host granted cycle 7, host granted cycles 8-10 (burst ends after 4), core granted cycle 11.
REQ-037 Host store addr 0x7FF data 0x12345678, core idle -> host_gnt=1, mem_we=1, mem_addr=0x7FF same cycle; no rvalid on either port.
REQ-038 S_HOST with host_req dropping while core_req=1 -> core granted that same cycle, core_stall=0, state S_CORE next cycle.
REQ-039 Core load granted, reset asserted before next edge -> core_rvalid stays 0 after deassertion, state S_CORE, counters 0.
REQ-040 Alternating core load (0x001) and host load (0x002) on consecutive grants -> core_rvalid then host_rvalid on consecutive cycles with matching data, never both high.
